// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
//   Transmit-only serial port: a DEPTH-entry byte FIFO in front of an 8N1
//   serialiser (LSB first, idle high), plus a small status register.
//
// Parameters
//   DIV    clocks per serial bit (2..65535)
//   DEPTH  FIFO entries, power of two (2..256)
//
// Ports
//   clock   in   system clock, all state on posedge
//   reset   in   asynchronous active-low reset
//   wvalid  in   single-cycle write strobe (address already qualified)
//   wdata   in   write data, bits [7:0] are the byte to send
//   rvalid  in   single-cycle status-read strobe (address already qualified)
//   raddr   in   read address, bits [2:0] decoded (5 = LSR)
//   rdata   out  registered read data
//   tx      out  serial line, registered
//   busy    out  FIFO non-empty or serialiser active
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int unsigned DIV   = 16,
  parameter int unsigned DEPTH = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wvalid,
  input  logic [31:0] wdata,
  input  logic        rvalid,
  input  logic [31:0] raddr,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        busy
);

  localparam int unsigned AW        = $clog2(DEPTH);
  localparam logic [15:0] BAUD_LAST = 16'(DIV - 1);
  localparam logic [AW:0] PTR_ONE   = (AW + 1)'(1);
  localparam logic [2:0]  LSR_ADDR  = 3'd5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // FIFO ---------------------------------------------------------------------
  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        empty;
  logic        full;
  logic        push;
  logic        pop;
  logic        ovf_set;

  // Serialiser ---------------------------------------------------------------
  state_t      state;
  state_t      state_nx;
  logic [15:0] baud_cnt;
  logic [15:0] baud_nx;
  logic [2:0]  bit_cnt;
  logic [2:0]  bit_nx;
  logic [7:0]  shift;
  logic [7:0]  shift_nx;
  logic        tx_nx;
  logic        baud_done;

  // Status -------------------------------------------------------------------
  logic        overflow;
  logic        lsr_rd;
  logic [31:0] lsr;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

  // A pop in the same cycle frees the slot, so a write to a full FIFO is
  // still accepted then. Pop is never raised when empty, so a write into an
  // empty FIFO is simply stored and taken on a later edge.
  assign push    = wvalid && (!full || pop);
  assign ovf_set = wvalid && full && !pop;

  assign baud_done = (baud_cnt == BAUD_LAST);

  // Next-state and datapath for the serialiser.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_nx = state;
    baud_nx  = baud_cnt;
    bit_nx   = bit_cnt;
    shift_nx = shift;
    tx_nx    = tx;
    pop      = 1'b0;

    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop      = 1'b1;
          state_nx = START;
          shift_nx = mem[rd_ptr[AW-1:0]];
          baud_nx  = '0;
          bit_nx   = '0;
          tx_nx    = 1'b0;
        end
      end

      START: begin
        if (baud_done) begin
          baud_nx  = '0;
          state_nx = DATA;
          tx_nx    = shift[0];
          shift_nx = {1'b0, shift[7:1]};
        end else begin
          baud_nx = baud_cnt + 16'd1;
        end
      end

      DATA: begin
        if (baud_done) begin
          baud_nx = '0;
          if (bit_cnt == 3'd7) begin
            state_nx = STOP;
            tx_nx    = 1'b1;
          end else begin
            tx_nx    = shift[0];
            shift_nx = {1'b0, shift[7:1]};
            bit_nx   = bit_cnt + 3'd1;
          end
        end else begin
          baud_nx = baud_cnt + 16'd1;
        end
      end

      STOP: begin
        if (baud_done) begin
          baud_nx = '0;
          if (!empty) begin
            // Chain straight into the next frame with no idle bit.
            pop      = 1'b1;
            state_nx = START;
            shift_nx = mem[rd_ptr[AW-1:0]];
            bit_nx   = '0;
            tx_nx    = 1'b0;
          end else begin
            state_nx = IDLE;
          end
        end else begin
          baud_nx = baud_cnt + 16'd1;
        end
      end

      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
    end else begin
      state    <= state_nx;
      baud_cnt <= baud_nx;
      bit_cnt  <= bit_nx;
      shift    <= shift_nx;
      tx       <= tx_nx;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // NOTE: the storage array has no reset; zeroing the pointers already makes
  // its contents unreachable, and leaving it unreset lets it map to RAM.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wdata[7:0];
  end

  // Status register ----------------------------------------------------------
  assign lsr_rd = rvalid && (raddr[2:0] == LSR_ADDR);

  assign lsr = {25'd0, empty && (state == IDLE), empty, 3'd0, overflow, 1'b0};

  // An overflow in the same cycle as an LSR read takes priority over the clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (ovf_set) begin
      overflow <= 1'b1;
    end else if (lsr_rd) begin
      overflow <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rdata <= '0;
    end else if (rvalid) begin
      rdata <= lsr_rd ? lsr : 32'd0;
    end
  end

  assign busy = !empty || (state != IDLE);

  // Upper bus bits are architecturally ignored.
  logic unused_bits;
  assign unused_bits = ^{wdata[31:8], raddr[31:3]};

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 Parameter DIV, default 16, SHALL set the clocks per serial bit; legal range is 2..65535.
REQ-003 Parameter DEPTH, default 16, SHALL set the FIFO entries; it is a power of two, 2..256.
REQ-004 Port: clock  input  1  system clock, all state on posedge.
REQ-005 Port: reset  input  1  asynchronous active-low reset.
REQ-006 Port: wvalid  input  1  single-cycle write strobe from the bus slave; already qualified by the serial-port address.
REQ-007 Port: wdata  input  32  write data; only bits [7:0] are used.
REQ-008 Port: rvalid  input  1  single-cycle status-read strobe, already address-qualified.
REQ-009 Port: raddr  input  32  read address; only bits [2:0] are decoded.
REQ-010 Port: rdata  output  32  registered status read data.
REQ-011 Port: tx  output  1  serial line, 8N1, LSB first, idle high.
REQ-012 Port: busy  output  1  high while the FIFO is non-empty or the FSM is not IDLE.

Function
REQ-013 Writes SHALL be accepted without backpressure: wvalid with FIFO not full pushes wdata[7:0] at that posedge.
REQ-014 wvalid with FIFO full SHALL drop the byte and set the sticky overflow flag; FIFO contents are unchanged.
REQ-015 If a push and a pop occur in the same cycle with the FIFO full, the pop SHALL free a slot and the push SHALL be accepted, with no overflow.
REQ-016 If a push and a pop occur in the same cycle with the FIFO empty, the pop SHALL NOT occur; the byte is stored and popped on a later cycle.
REQ-017 FIFO pointers SHALL be log2(DEPTH)+1 bits wide and wrap modulo 2*DEPTH. Full is indicated by equal index bits and differing MSB; empty by equal pointers.
REQ-018 The FSM SHALL have four states: IDLE, START, DATA, STOP.
REQ-019 IDLE -> START SHALL occur on the first posedge where the FIFO is non-empty. At that edge the head byte is popped into the shift register, the bit counter and the baud counter clear, and tx is registered low.
REQ-020 Each of START, DATA and STOP SHALL hold each bit for exactly DIV clocks, counted by a baud counter from 0 to DIV-1.
REQ-021 START -> DATA SHALL occur after DIV clocks; DATA SHALL output shift[0], shift right and increment the bit counter every DIV clocks.
REQ-022 DATA -> STOP SHALL occur after bit 7 completes; tx is 1 in STOP.
REQ-023 STOP -> START SHALL occur after DIV clocks if the FIFO is non-empty, popping the next byte with no idle gap; otherwise STOP -> IDLE.
REQ-024 tx SHALL be driven from a flop, never combinationally.
REQ-025 One frame SHALL be 10*DIV clocks.
REQ-026 Write-to-start latency from an empty, idle state SHALL be 2 edges: the push at edge N makes tx low after edge N+1.
REQ-027 On rvalid, rdata SHALL register at the next edge. For raddr[2:0]==5 (LSR):
- bit0 = 0
- bit1 = overflow
- bit5 = FIFO empty
- bit6 = FIFO empty and FSM IDLE
- all other bits 0
REQ-028 For raddr[2:0]!=5, rdata SHALL register 0.
REQ-029 An LSR read SHALL clear overflow in the same edge, returning the pre-clear value. An overflow event in that same cycle wins and leaves the flag set.
REQ-030 rdata SHALL hold its value between reads.
REQ-031 busy SHALL be combinational from the FIFO-empty flag and the FSM state.

Reset
REQ-032 While reset is low, the block SHALL hold: tx=1, FSM=IDLE, both pointers=0, overflow=0, rdata=0, baud counter=0, bit counter=0.
REQ-033 Assertion mid-frame SHALL abort the frame immediately, with tx high asynchronously, and discard all FIFO contents.
REQ-034 After deassertion, nothing SHALL transmit until a new write.
REQ-035 FIFO storage contents need no reset.

Verification
REQ-036 Single byte, DIV=4: write 0x55 to the empty FIFO at edge N. Required: tx low at N+1..N+4, then bits 1,0,1,0,1,0,1,0 at 4 clocks each, then stop high for 4 clocks; busy falls exactly 40 clocks after N+1.
REQ-037 Back-to-back frames: write 0x00 then 0xFF on consecutive cycles. Required: the second start bit follows the first stop bit with zero idle clocks, and the total busy time is 80 clocks at DIV=4.
REQ-038 Overflow: with the FSM holding one byte and the FIFO filled with DEPTH bytes (DEPTH+1 writes), send one more write, then read LSR. Required: rdata=0x00000002; a second LSR read returns bit1=0; exactly DEPTH+1 frames are transmitted, in order.
REQ-039 Pointer wrap: stream 3*DEPTH+3 bytes, 0x00 incrementing, spaced one frame apart. Required: serial output matches the incrementing sequence with no loss and no overflow.
REQ-040 Full-cycle push/pop: fill the FIFO, then write exactly on the STOP->START pop edge. Required: the byte is accepted, overflow stays 0, and the sequence is intact.
REQ-041 Reset mid-frame: assert reset during DATA bit 3 with 5 bytes queued. Required: tx=1 immediately and an LSR read after release returns 0x00000060; no frames follow.
